// File: rtl/seg7_scan_driver_if.sv
// Display-side bus of the 7-segment scan driver: the datapath loads the
// display word and level controls, the driver returns the pin outputs.
interface seg7_scan_driver_if;
   logic        load;
   logic [31:0] data_in;
   logic [7:0]  dp_in;
   logic        blank_lz;
   logic [7:0]  blink_mask;
   logic [7:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic [2:0]  digit_idx;

   modport master (
      output load, data_in, dp_in, blank_lz, blink_mask,
      input  an, seg, dp, digit_idx
   );

   modport slave (
      input  load, data_in, dp_in, blank_lz, blink_mask,
      output an, seg, dp, digit_idx
   );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for eight common-anode 7-segment digits.
// One digit is advanced per refresh_clk rising edge; anode, segment and
// decimal-point pins are active-low and come from a single register stage.
module seg7_scan_driver #(
   parameter int unsigned BLINK_DIV = 120
) (
   input  logic                clk_in,
   input  logic                reset,
   input  logic                refresh_clk,
   seg7_scan_driver_if.slave   bus
);

   localparam int unsigned CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_DIV - 1);

   logic          rf_q1;
   logic          rf_q2;
   logic          tick;
   logic [2:0]    digit_idx;
   logic [31:0]   disp_word;
   logic [7:0]    disp_dp;
   logic [CW-1:0] blink_cnt;
   logic          blink_phase;

   logic [7:0]    an_q;
   logic [6:0]    seg_q;
   logic          dp_q;

   logic [7:0]    lz_zero;
   logic          lz_run;
   logic [3:0]    nibble;
   logic          blanked;
   logic [7:0]    an_d;
   logic [6:0]    seg_d;
   logic          dp_d;

   // Active-low {a,b,c,d,e,f,g} pattern for one hex nibble.
   function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
      logic [6:0] s;
      unique case (h)
         4'h0: s = 7'b0000001;
         4'h1: s = 7'b1001111;
         4'h2: s = 7'b0010010;
         4'h3: s = 7'b0000110;
         4'h4: s = 7'b1001100;
         4'h5: s = 7'b0100100;
         4'h6: s = 7'b0100000;
         4'h7: s = 7'b0001111;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0000100;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b1100000;
         4'hC: s = 7'b0110001;
         4'hD: s = 7'b1000010;
         4'hE: s = 7'b0110000;
         4'hF: s = 7'b0111000;
         default: s = 7'b1111111;
      endcase
      return s;
   endfunction

   assign tick = rf_q1 & ~rf_q2;

   // Synchronise and edge-detect the refresh square wave.
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         rf_q1 <= 1'b0;
         rf_q2 <= 1'b0;
      end else begin
         rf_q1 <= refresh_clk;
         rf_q2 <= rf_q1;
      end
   end

   // Scan counter: one digit per refresh edge, wrapping after digit 7.
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         digit_idx <= '0;
      end else if (tick) begin
         digit_idx <= digit_idx + 3'd1;
      end
   end

   // Display word and decimal points captured from the datapath.
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         disp_word <= '0;
         disp_dp   <= '0;
      end else if (bus.load) begin
         disp_word <= bus.data_in;
         disp_dp   <= bus.dp_in;
      end
   end

   // Blink timebase: phase toggles every BLINK_DIV scan ticks, starts visible.
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b1;
      end else if (tick) begin
         if (blink_cnt == BLINK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
         end
      end
   end

   // lz_zero[i] is set when nibbles i..7 are all zero; digit 0 never qualifies.
   always_comb begin
      lz_zero = '0;
      lz_run  = 1'b1;
      for (int unsigned j = 0; j < 8; j++) begin
         lz_run         = lz_run & (disp_word[(7 - j) * 4 +: 4] == 4'h0);
         lz_zero[7 - j] = lz_run;
      end
      lz_zero[0] = 1'b0;
   end

   // Next pin values for the digit currently selected.
   always_comb begin
      nibble  = disp_word[{digit_idx, 2'b00} +: 4];
      blanked = (bus.blank_lz & lz_zero[digit_idx]) |
                (~blink_phase & bus.blink_mask[digit_idx]);
      an_d    = ~(8'd1 << digit_idx);
      seg_d   = hex_to_seg(nibble);
      dp_d    = ~disp_dp[digit_idx];
      if (blanked) begin
         an_d  = '1;
         seg_d = '1;
         dp_d  = 1'b1;
      end
   end

   // Single output register stage keeps the pins glitch-free.
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         an_q  <= '1;
         seg_q <= '1;
         dp_q  <= 1'b1;
      end else begin
         an_q  <= an_d;
         seg_q <= seg_d;
         dp_q  <= dp_d;
      end
   end

   assign bus.an        = an_q;
   assign bus.seg       = seg_q;
   assign bus.dp        = dp_q;
   assign bus.digit_idx = digit_idx;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with hand-computed expected pin values.
module tb_seg7_scan_driver;

   logic clk_in      = 1'b0;
   logic reset       = 1'b1;
   logic refresh_clk = 1'b0;

   int checks = 0;
   int errors = 0;

   seg7_scan_driver_if bus();

   seg7_scan_driver #(.BLINK_DIV(4)) dut (
      .clk_in      (clk_in),
      .reset       (reset),
      .refresh_clk (refresh_clk),
      .bus         (bus)
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
      end
   endtask

   task automatic refresh_pulse();
      @(negedge clk_in) refresh_clk = 1'b1;
      repeat (3) @(negedge clk_in);
      refresh_clk = 1'b0;
      repeat (3) @(negedge clk_in);
   endtask

   task automatic load_word(input logic [31:0] w, input logic [7:0] d);
      @(negedge clk_in);
      bus.load    = 1'b1;
      bus.data_in = w;
      bus.dp_in   = d;
      @(negedge clk_in);
      bus.load = 1'b0;
      @(negedge clk_in);
   endtask

   initial begin
      logic [2:0] exp_idx;
      logic       exp_phase;
      logic [7:0] one_hot_n;

      bus.load       = 1'b0;
      bus.data_in    = '0;
      bus.dp_in      = '0;
      bus.blank_lz   = 1'b0;
      bus.blink_mask = '0;

      // Reset values, then digit 0 of an all-zero word.
      repeat (3) @(negedge clk_in);
      check("rst_an",  32'(bus.an),  32'hFF);
      check("rst_seg", 32'(bus.seg), 32'h7F);
      check("rst_dp",  32'(bus.dp),  32'h1);
      check("rst_idx", 32'(bus.digit_idx), 32'h0);
      reset = 1'b0;
      @(negedge clk_in);
      check("idle_an",  32'(bus.an),  32'hFE);
      check("idle_seg", 32'(bus.seg), 32'(7'b0000001));

      // Scan through all digits of 89ABCDEF with dp on digit 0.
      load_word(32'h89AB_CDEF, 8'h01);
      check("d0_seg", 32'(bus.seg), 32'(7'b0111000));
      check("d0_dp",  32'(bus.dp),  32'h0);
      check("d0_an",  32'(bus.an),  32'hFE);
      @(negedge clk_in) refresh_clk = 1'b1;
      @(negedge clk_in);
      check("lat_e0_idx", 32'(bus.digit_idx), 32'h0);
      @(negedge clk_in);
      check("lat_e1_idx", 32'(bus.digit_idx), 32'h1);
      check("lat_e1_an",  32'(bus.an), 32'hFE);
      @(negedge clk_in);
      check("lat_e2_an",  32'(bus.an), 32'hFD);
      check("lat_e2_seg", 32'(bus.seg), 32'(7'b0110000));
      check("lat_e2_dp",  32'(bus.dp), 32'h1);
      refresh_clk = 1'b0;
      repeat (3) @(negedge clk_in);
      for (int k = 2; k <= 9; k++) begin
         refresh_pulse();
         exp_idx   = 3'(k % 8);
         one_hot_n = ~(8'd1 << exp_idx);
         check("scan_idx", 32'(bus.digit_idx), 32'(exp_idx));
         check("scan_an",  32'(bus.an), 32'(one_hot_n));
         if (k == 7) check("d7_seg", 32'(bus.seg), 32'(7'b0000000));
         if (k == 8) check("wrap_seg", 32'(bus.seg), 32'(7'b0111000));
      end

      // Asynchronous reset mid-scan, then first tick selects digit 1.
      @(negedge clk_in);
      #2 reset = 1'b1;
      #1;
      check("async_an",  32'(bus.an),  32'hFF);
      check("async_seg", 32'(bus.seg), 32'h7F);
      check("async_dp",  32'(bus.dp),  32'h1);
      check("async_idx", 32'(bus.digit_idx), 32'h0);
      @(negedge clk_in) reset = 1'b0;
      @(negedge clk_in);
      check("post_rst_an",  32'(bus.an),  32'hFE);
      check("post_rst_seg", 32'(bus.seg), 32'(7'b0000001));
      refresh_pulse();
      check("post_rst_idx", 32'(bus.digit_idx), 32'h1);

      // Leading-zero blanking.
      bus.blank_lz = 1'b1;
      load_word(32'h0000_0050, 8'h00);
      check("lz_d1_an",  32'(bus.an),  32'hFD);
      check("lz_d1_seg", 32'(bus.seg), 32'(7'b0100100));
      refresh_pulse();
      check("lz_d2_an",  32'(bus.an),  32'hFF);
      check("lz_d2_seg", 32'(bus.seg), 32'h7F);
      check("lz_d2_dp",  32'(bus.dp),  32'h1);
      repeat (6) refresh_pulse();
      check("lz_d0_idx", 32'(bus.digit_idx), 32'h0);
      check("lz_d0_an",  32'(bus.an),  32'hFE);
      check("lz_d0_seg", 32'(bus.seg), 32'(7'b0000001));
      load_word(32'h0, 8'h00);
      check("lz0_d0_an",  32'(bus.an),  32'hFE);
      check("lz0_d0_seg", 32'(bus.seg), 32'(7'b0000001));
      refresh_pulse();
      check("lz0_d1_an", 32'(bus.an), 32'hFF);
      bus.blank_lz = 1'b0;

      // Blink with BLINK_DIV=4: phase flips every 4 ticks from reset.
      @(negedge clk_in) reset = 1'b1;
      @(negedge clk_in) reset = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         refresh_pulse();
         exp_idx   = 3'(k % 8);
         exp_phase = ((k / 4) % 2) == 0;
         one_hot_n = ~(8'd1 << exp_idx);
         bus.blink_mask = 8'h01;
         @(negedge clk_in);
         check("blk_m01_an", 32'(bus.an),
               32'((exp_idx == 3'd0 && !exp_phase) ? 8'hFF : one_hot_n));
         bus.blink_mask = 8'd1 << exp_idx;
         @(negedge clk_in);
         check("blk_cur_an", 32'(bus.an), 32'(exp_phase ? one_hot_n : 8'hFF));
         bus.blink_mask = 8'h00;
         @(negedge clk_in);
      end

      // Load in the same cycle as tick: next digit shows the new nibble at E2.
      @(negedge clk_in) refresh_clk = 1'b1;
      @(negedge clk_in);
      bus.load    = 1'b1;
      bus.data_in = 32'h0000_00A0;
      bus.dp_in   = 8'h00;
      @(negedge clk_in);
      bus.load = 1'b0;
      check("lot_e1_idx", 32'(bus.digit_idx), 32'h1);
      check("lot_e1_an",  32'(bus.an), 32'hFE);
      @(negedge clk_in);
      check("lot_e2_an",  32'(bus.an),  32'hFD);
      check("lot_e2_seg", 32'(bus.seg), 32'(7'b0001000));
      refresh_clk = 1'b0;
      repeat (3) @(negedge clk_in);

      // Stalled refresh: held high, then held low, scan frozen.
      @(negedge clk_in) refresh_clk = 1'b1;
      repeat (1000) @(negedge clk_in);
      check("stall_hi_idx", 32'(bus.digit_idx), 32'h2);
      check("stall_hi_an",  32'(bus.an),  32'hFB);
      check("stall_hi_seg", 32'(bus.seg), 32'(7'b0000001));
      refresh_clk = 1'b0;
      repeat (1000) @(negedge clk_in);
      check("stall_lo_idx", 32'(bus.digit_idx), 32'h2);
      check("stall_lo_an",  32'(bus.an), 32'hFB);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed driver for the eight common-anode 7-segment digits on the Nexys 4. It consumes the 480 Hz refresh square wave from the refresh clock divider, advances one digit per refresh rising edge and drives the active-low anode, segment and decimal-point pins. Each digit is therefore lit at 60 Hz. It holds a 32-bit hex display word loaded by the datapath, with leading-zero blanking and per-digit blinking.

## Interface
- BLINK_DIV, 120: scan ticks per blink half-period (480/120 gives 4 toggles/s, i.e. 2 Hz blink).
- clk_in  in  1  100 MHz system clock; all state is on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- refresh_clk  in  1  480 Hz square wave from the divider, generated from clk_in; treated as a level and edge-detected.
- load  in  1  when high at a clk_in edge, captures data_in and dp_in.
- data_in  in  32  eight hex nibbles; digit 0 = [3:0] (rightmost), digit 7 = [31:28].
- dp_in  in  8  decimal-point enables, bit i = digit i, active-high.
- blank_lz  in  1  leading-zero blanking enable (level, not captured).
- blink_mask  in  8  bit i set = digit i blinks (level, not captured).
- an  out  8  anode enables, active-low, at most one bit low.
- seg  out  7  segments {a,b,c,d,e,f,g} = seg[6:0], active-low.
- dp  out  1  decimal point, active-low.
- digit_idx  out  3  index of the digit currently being scanned.

## Operation
- Edge detect: two flops rf_q1 and rf_q2 sample refresh_clk. tick = rf_q1 & ~rf_q2 is a one-cycle pulse per refresh rising edge.
- Scan counter: on tick, digit_idx increments 0→1→…→7→0 (3-bit wrap). It holds otherwise.
- Display registers: disp_word (32) and disp_dp (8) load on load, independent of tick. Load and tick in the same cycle both take effect.
- Hex decode, active-low {a..g}:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
- Leading-zero blanking: digit i (i≥1) is blanked when blank_lz=1 and nibbles i..7 of disp_word are all zero. Digit 0 is never LZ-blanked.
- Blink: blink_cnt counts ticks from 0 to BLINK_DIV-1. On the tick where it reaches BLINK_DIV-1 it clears and blink_phase toggles. blink_phase resets to 1 (visible). When blink_phase=0, digits with blink_mask[i]=1 are blanked.
- Blanked digit: an = 8'hFF, seg = 7'h7F and dp = 1 for that scan slot; the slot is still consumed.
- Lit digit: an = ~(1<<digit_idx), seg = decode(nibble[digit_idx]), dp = ~disp_dp[digit_idx].
- an, seg and dp are registered, recomputed every clk_in cycle from current digit_idx, registers and level inputs.

## Timing
- Reset values:
  - an=8'hFF, seg=7'h7F, dp=1, digit_idx=0.
  - disp_word=0, disp_dp=0.
  - blink_cnt=0, blink_phase=1, rf_q1=rf_q2=0.
- Refresh to scan latency: refresh_clk first sampled high at edge E0 (rf_q1). tick is high during E0→E1, digit_idx changes at E1, an/seg/dp change at E2.
- Load latency: load high at edge L. disp_word updates at L and outputs reflect the new data at L+1.
- blank_lz and blink_mask changes reach the outputs one edge later.
- refresh_clk held high or low produces no tick; the scan freezes with the current digit still driven.
- Reset asserted mid-scan forces all reset values asynchronously. After release, the first tick selects digit 1.
- Outputs are glitch-free: single registered stage, one anode low per cycle.

## Test plan
- Reset: assert reset mid-scan → an=FF, seg=7F, dp=1, digit_idx=0 without waiting for a clock. After release with no refresh edges, outputs show digit 0 of word 0: an=FE, seg=0000001.
- Scan/wrap: load 32'h89AB_CDEF, dp_in=8'h01; drive 9 refresh edges → digit_idx 1..7,0,1. Digit 0 shows seg=0111000 (F), dp=0, an=FE. Digit 7 shows seg=0000000, an=7F. Check the E0→E2 latency.
- Leading-zero: load 32'h0000_0050, blank_lz=1 → digits 2..7 have an=FF, digit 1 shows 0100100, digit 0 shows 0000001. Load 32'h0 → digit 0 still shows 0000001.
- Blink: BLINK_DIV=4, blink_mask=8'h01 → digit 0 dark for 4 ticks, lit for 4 ticks, alternating. Other digits are always lit.
- Load on tick: assert load in the same cycle as tick, with the new value differing at the next digit → that digit shows the new nibble at E2.
- Stalled refresh: hold refresh_clk high for 1000 cycles → digit_idx constant and no tick.
